// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
// Bit timing is derived from the system clock by an internal divider.
`timescale 1ns/1ps
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tx_start,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  output logic                  o_tx_done,
  output logic                  o_tx_data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [IW-1:0]         idx, idx_d, idx_inc;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic                  tx, tx_d;
  logic                  done, done_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      tx    <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shreg <= shreg_d;
      tx    <= tx_d;
      done  <= done_d;
    end
  end

  // Line value is computed for the state being entered so the output stays registered.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shreg_d = shreg;
    tx_d    = tx;
    done_d  = 1'b0;
    idx_inc = idx + 1'b1;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (i_tx_start) begin
          shreg_d = i_data_in;
          cnt_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
          tx_d    = shreg[0];
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (idx == IDX_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_inc;
            tx_d  = shreg[idx_inc];
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign o_tx_data = tx;
  assign o_tx_done = done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a fast instance (4 clocks/bit) and a real-rate instance (434 clocks/bit),
// both compared cycle by cycle against a frame-waveform reference model.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [7:0] data_a, data_b;
  logic       done_a, done_b, tx_a, tx_b;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int done_cyc;
  int prev_done;

  always #10 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_tx_start(start_a), .i_data_in(data_a),
    .o_tx_done(done_a), .o_tx_data(tx_a)
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(434)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_tx_start(start_b), .i_data_in(data_b),
    .o_tx_done(done_b), .o_tx_data(tx_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cycle);
    end
  endtask

  task automatic check_int(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Line level j cycles after the start-sampling edge of a frame carrying w.
  function automatic logic exp_line(input logic [7:0] w, input int j, input int c);
    if (j < c) return 1'b0;
    if (j < 9 * c) return w[j / c - 1];
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_line", tx_a, 1'b1);
      check("idle_done", done_a, 1'b0);
    end
  endtask

  // Runs one frame from IDLE; ends right after the done edge unless aborted by reset.
  task automatic frame(input bit big, input logic [7:0] word, input bit keep,
                       input int change_at, input logic [7:0] alt, input int abort_at);
    int     c;
    int     total;
    longint t0;
    c     = big ? 434 : 4;
    total = 10 * c;
    if (big) begin data_b = word; start_b = 1'b1; end
    else     begin data_a = word; start_a = 1'b1; end
    tick();
    t0 = $time - 1;
    for (int j = 0; j <= total; j++) begin
      if (j == abort_at) begin
        rst = 1'b1;
        start_a = 1'b0;
        tick();
        check("rst_line", tx_a, 1'b1);
        check("rst_done", done_a, 1'b0);
        rst = 1'b0;
        return;
      end
      check(big ? "line_b" : "line_a", big ? tx_b : tx_a, exp_line(word, j, c));
      check(big ? "done_b" : "done_a", big ? done_b : done_a, j == total);
      if (j == 0 && !keep) begin
        if (big) start_b = 1'b0; else start_a = 1'b0;
      end
      if (j == change_at) begin
        if (big) data_b = alt; else data_a = alt;
      end
      if (j < total) tick();
    end
    done_cyc = cycle;
    if (big) check_int("frame_time_ns", $time - 1 - t0, 64'd86800);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] a;
    bit         k;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;

    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_line", tx_a, 1'b1);
      check("reset_done", done_a, 1'b0);
    end
    rst = 1'b0;
    idle(4);

    frame(0, 8'hA5, 0, -1, 8'h00, -1);
    idle(8);

    frame(0, 8'h3C, 1, -1, 8'h00, -1);
    prev_done = done_cyc;
    frame(0, 8'hFF, 1, -1, 8'h00, -1);
    check_int("done_spacing1", done_cyc - prev_done, 41);
    prev_done = done_cyc;
    frame(0, 8'h00, 0, -1, 8'h00, -1);
    check_int("done_spacing2", done_cyc - prev_done, 41);
    idle(3);

    frame(0, 8'h5A, 0, 13, 8'hC3, -1);
    idle(2);

    frame(0, 8'h96, 0, -1, 8'h00, 25);
    idle(12);
    frame(0, 8'h81, 0, -1, 8'h00, -1);
    idle(2);

    for (int i = 0; i < 8; i++) begin
      w = 8'($urandom);
      a = 8'($urandom);
      k = (i < 7) ? bit'($urandom_range(0, 1)) : 1'b0;
      frame(0, w, k, int'($urandom_range(1, 39)), a, -1);
      if (!k) idle(int'($urandom_range(1, 3)));
    end

    frame(1, 8'h55, 0, -1, 8'h00, -1);
    tick();
    check("big_idle_line", tx_b, 1'b1);
    check("big_idle_done", done_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serialises a DATA_WIDTH-bit parallel word onto a single line in 8N1 style (1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit, no parity).
- Bit timing comes from an internal divider of the system clock.
- Sits between a byte-producing host and the TX pin. It pulses a done strobe after each frame so the host can present the next word.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (≥1).
- CLKS_PER_BIT, 434, system-clock cycles per serial bit (434 gives 115200 baud at 50 MHz). Must be ≥2.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_tx_start  input  1  level request to transmit; sampled only in IDLE.
- i_data_in  input  DATA_WIDTH  word to send; sampled only when a frame starts.
- o_tx_done  output  1  one-cycle pulse marking frame completion.
- o_tx_data  output  1  serial line; idles high.

Behaviour:
- Reset (i_rst high at a rising edge) puts the block in IDLE with o_tx_data=1 and o_tx_done=0. This applies mid-frame as well: the frame is abandoned, no done pulse is produced, and the line returns high on that edge.
- All outputs are registered. The bit counter is $clog2(CLKS_PER_BIT) wide and the data-bit index is $clog2(DATA_WIDTH) wide (minimum 1).
- States:
  - IDLE: o_tx_data=1. If i_tx_start=1 at an edge:
    - latch i_data_in into the shift register;
    - clear the bit counter;
    - go to START.
  - START: o_tx_data=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx_data=shreg[index] for CLKS_PER_BIT cycles per bit, LSB first. After bit DATA_WIDTH-1, go to STOP.
  - STOP: o_tx_data=1 for CLKS_PER_BIT cycles, then go to IDLE and assert o_tx_done for exactly that one IDLE cycle.
- Timing: if i_tx_start is sampled at edge k, then:
  - o_tx_data falls after edge k;
  - data bit n drives from edge k+(n+1)·CLKS_PER_BIT;
  - the stop bit begins at k+(DATA_WIDTH+1)·CLKS_PER_BIT;
  - o_tx_done is high from edge k+(DATA_WIDTH+2)·CLKS_PER_BIT for one cycle.
- Back-to-back operation: with i_tx_start held high, a new frame starts on the edge after the done pulse. Consequences:
  - there is exactly one idle-high cycle between frames;
  - the frame period is (DATA_WIDTH+2)·CLKS_PER_BIT+1 cycles;
  - a word driven in response to the done pulse is captured for the next frame.
- i_data_in changes during a frame have no effect on that frame.
- Deasserting i_tx_start mid-frame has no effect; the current frame always completes.
- o_tx_done is never high outside the single post-STOP IDLE cycle. It is never asserted twice per frame.
- No glitches on o_tx_data: it changes only at bit boundaries.

Test Plan:
- Set CLKS_PER_BIT=4, DATA_WIDTH=8. Hold reset 5 cycles -> o_tx_data=1, o_tx_done=0 throughout reset and while idle with i_tx_start=0.
- Send 0xA5 with a single start request -> line shows 0 (4 cycles), then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles). o_tx_done pulses for 1 cycle 40 cycles after the start sample. The line then stays high.
- Hold i_tx_start=1 and drive 0x3C, 0xFF, 0x00, each new word on the cycle after o_tx_done -> three consecutive frames carrying those words. Each has exactly 1 idle-high cycle before the next start bit. Done pulses are 41 cycles apart.
- Change i_data_in from 0x5A to 0xC3 during the third data bit -> transmitted word is 0x5A.
- Assert i_rst during data bit 5 of a frame -> o_tx_data=1 at the next edge, no o_tx_done pulse. A subsequent request of 0x81 transmits correctly from a fresh start bit.
- Set CLKS_PER_BIT=434. Send 0x55 with a 20 ns clock -> each bit lasts 8.68 µs, and the frame ends with a done pulse 86.8 µs after the start sample.
